// File: rtl/int_issue_queue.sv
// Age-ordered compacting integer issue queue. Holds dispatched instructions until both
// operands are valid, snoops the CDB for wakeup, and presents the oldest ready entry.
module int_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_dispatch_en,
  input  logic [2:0]  i_dispatch_opcode,
  input  logic [4:0]  i_dispatch_rd_tag,
  input  logic        i_dispatch_rs_valid,
  input  logic        i_dispatch_rt_valid,
  input  logic [4:0]  i_dispatch_rs_tag,
  input  logic [4:0]  i_dispatch_rt_tag,
  input  logic [31:0] i_dispatch_rs_data,
  input  logic [31:0] i_dispatch_rt_data,
  output logic        o_queue_full,
  input  logic        i_cdb_valid,
  input  logic [4:0]  i_cdb_tag,
  input  logic [31:0] i_cdb_data,
  output logic        o_ready_int,
  input  logic        i_issue_int,
  output logic [2:0]  o_issue_opcode,
  output logic [4:0]  o_issue_rd_tag,
  output logic [31:0] o_issue_rs_data,
  output logic [31:0] o_issue_rt_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic [2:0]  opcode;
    logic [4:0]  rd_tag;
    logic        rs_valid;
    logic [4:0]  rs_tag;
    logic [31:0] rs_data;
    logic        rt_valid;
    logic [4:0]  rt_tag;
    logic [31:0] rt_data;
  } entry_t;

  entry_t          r_q [DEPTH];
  logic [CW-1:0]   r_count;

  entry_t          w_nxt [DEPTH];
  entry_t          w_disp_entry;
  logic [CW-1:0]   w_nxt_count;
  logic [CW-1:0]   w_disp_idx;
  logic [DEPTH-1:0] w_ready;
  logic [IW-1:0]   w_sel;
  logic            w_any;
  logic            w_do_issue;
  logic            w_do_disp;
  logic            w_rs_byp;
  logic            w_rt_byp;

  // Captures a matching CDB broadcast into any still-missing operand of an entry.
  function automatic entry_t snoop(entry_t e, logic v, logic [4:0] tag, logic [31:0] data);
    entry_t r;
    r = e;
    if (v && e.valid) begin
      if (!e.rs_valid && e.rs_tag == tag) begin
        r.rs_valid = 1'b1;
        r.rs_data  = data;
      end
      if (!e.rt_valid && e.rt_tag == tag) begin
        r.rt_valid = 1'b1;
        r.rt_data  = data;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_q[i].valid & r_q[i].rs_valid & r_q[i].rt_valid;
    end
  end

  // Scan from the top so the lowest-index (oldest) ready entry wins.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel = IW'(i);
        w_any = 1'b1;
      end
    end
  end

  assign o_queue_full    = (r_count == CW'(DEPTH));
  assign o_ready_int     = w_any;
  assign o_issue_opcode  = w_any ? r_q[w_sel].opcode  : '0;
  assign o_issue_rd_tag  = w_any ? r_q[w_sel].rd_tag  : '0;
  assign o_issue_rs_data = w_any ? r_q[w_sel].rs_data : '0;
  assign o_issue_rt_data = w_any ? r_q[w_sel].rt_data : '0;

  assign w_do_issue = i_issue_int & w_any;
  assign w_do_disp  = i_dispatch_en & ~o_queue_full;
  assign w_rs_byp   = i_cdb_valid & ~i_dispatch_rs_valid & (i_dispatch_rs_tag == i_cdb_tag);
  assign w_rt_byp   = i_cdb_valid & ~i_dispatch_rt_valid & (i_dispatch_rt_tag == i_cdb_tag);
  assign w_disp_idx = r_count - CW'(w_do_issue);
  assign w_nxt_count = r_count + CW'(w_do_disp) - CW'(w_do_issue);

  always_comb begin
    w_disp_entry          = '0;
    w_disp_entry.valid    = 1'b1;
    w_disp_entry.opcode   = i_dispatch_opcode;
    w_disp_entry.rd_tag   = i_dispatch_rd_tag;
    w_disp_entry.rs_valid = i_dispatch_rs_valid | w_rs_byp;
    w_disp_entry.rs_tag   = i_dispatch_rs_tag;
    w_disp_entry.rs_data  = w_rs_byp ? i_cdb_data : i_dispatch_rs_data;
    w_disp_entry.rt_valid = i_dispatch_rt_valid | w_rt_byp;
    w_disp_entry.rt_tag   = i_dispatch_rt_tag;
    w_disp_entry.rt_data  = w_rt_byp ? i_cdb_data : i_dispatch_rt_data;
  end

  // Entries at or above the issued slot pull from the slot above; snoop rides along the shift.
  always_comb begin
    int src;
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = '0;
      src = (w_do_issue && i >= int'(w_sel)) ? i + 1 : i;
      if (src < DEPTH) begin
        w_nxt[i] = snoop(r_q[IW'(src)], i_cdb_valid, i_cdb_tag, i_cdb_data);
      end
      if (w_do_disp && i == int'(w_disp_idx)) begin
        w_nxt[i] = w_disp_entry;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_count <= w_nxt_count;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nxt[i];
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: every issue request pushes its expected response into
// a scoreboard queue that a separate monitor pops and compares.
module tb_int_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        d_en;
  logic [2:0]  d_op;
  logic [4:0]  d_rd;
  logic        d_rsv, d_rtv;
  logic [4:0]  d_rstag, d_rttag;
  logic [31:0] d_rsd, d_rtd;
  logic        full;
  logic        cdb_v;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ready;
  logic        issue;
  logic [2:0]  iss_op;
  logic [4:0]  iss_rd;
  logic [31:0] iss_rs, iss_rt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rdy;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  int_issue_queue #(.DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_dispatch_en(d_en), .i_dispatch_opcode(d_op), .i_dispatch_rd_tag(d_rd),
    .i_dispatch_rs_valid(d_rsv), .i_dispatch_rt_valid(d_rtv),
    .i_dispatch_rs_tag(d_rstag), .i_dispatch_rt_tag(d_rttag),
    .i_dispatch_rs_data(d_rsd), .i_dispatch_rt_data(d_rtd),
    .o_queue_full(full),
    .i_cdb_valid(cdb_v), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .o_ready_int(ready), .i_issue_int(issue),
    .o_issue_opcode(iss_op), .o_issue_rd_tag(iss_rd),
    .o_issue_rs_data(iss_rs), .o_issue_rt_data(iss_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    flush = 0; d_en = 0; d_op = 0; d_rd = 0; d_rsv = 0; d_rtv = 0;
    d_rstag = 0; d_rttag = 0; d_rsd = 0; d_rtd = 0;
    cdb_v = 0; cdb_tag = 0; cdb_data = 0; issue = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_disp(input logic [2:0] op, input logic [4:0] rd,
                          input logic rsv, input logic [4:0] rstag, input logic [31:0] rsd,
                          input logic rtv, input logic [4:0] rttag, input logic [31:0] rtd);
    d_en = 1; d_op = op; d_rd = rd;
    d_rsv = rsv; d_rstag = rstag; d_rsd = rsd;
    d_rtv = rtv; d_rttag = rttag; d_rtd = rtd;
  endtask

  task automatic disp_rdy(input logic [2:0] op, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd);
    set_disp(op, rd, 1, 0, rsd, 1, 0, rtd);
  endtask

  task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data);
    cdb_v = 1; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic set_issue(input logic rdy, input logic [2:0] op, input logic [4:0] rd,
                           input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    e.rdy = rdy; e.op = op; e.rd = rd; e.rs = rs; e.rt = rt;
    exp_q.push_back(e);
    issue = 1;
  endtask

  // Monitor: whenever the arbiter grant is up, the presented entry must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (issue === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: grant seen with empty scoreboard at %0t", $time);
        end else begin
          m_e = exp_q.pop_front();
          chk("iss_ready",  {31'b0, ready}, {31'b0, m_e.rdy});
          chk("iss_opcode", {29'b0, iss_op}, {29'b0, m_e.op});
          chk("iss_rdtag",  {27'b0, iss_rd}, {27'b0, m_e.rd});
          chk("iss_rsdata", iss_rs, m_e.rs);
          chk("iss_rtdata", iss_rt, m_e.rt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1;
    #3;
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_full",  {31'b0, full}, 0);
    chk("rst_rdtag", {27'b0, iss_rd}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Basic dispatch and issue
    disp_rdy(2, 5, 10, 20); tick();
    chk("t1_ready", {31'b0, ready}, 1);
    chk("t1_full",  {31'b0, full}, 0);
    set_issue(1, 2, 5, 10, 20); tick();
    chk("t1_empty", {31'b0, ready}, 0);

    // Wakeup: Rs waits on tag 7; Rt is valid but carries tag 8 that must be ignored
    set_disp(1, 3, 0, 7, 32'hDEAD, 1, 8, 1); tick();
    chk("t2_wait", {31'b0, ready}, 0);
    set_cdb(8, 32'h55); tick();
    chk("t2_wrongtag", {31'b0, ready}, 0);
    set_cdb(7, 32'hAA); tick();
    chk("t2_woken", {31'b0, ready}, 1);
    chk("t2_rsdata", iss_rs, 32'hAA);
    set_cdb(8, 32'hBB); tick();
    set_issue(1, 1, 3, 32'hAA, 1); tick();
    chk("t2_empty", {31'b0, ready}, 0);

    // Age order with a hole; snoop during shift
    set_disp(3, 10, 0, 9, 0, 1, 0, 2); tick();          // A waits tag 9
    disp_rdy(4, 11, 32'h11, 32'h12); tick();            // B
    disp_rdy(5, 12, 32'h21, 32'h22); tick();            // C
    set_disp(7, 14, 1, 0, 32'h41, 0, 14, 0); tick();    // E waits tag 14
    chk("t3_full", {31'b0, full}, 1);
    chk("t3_selB", {27'b0, iss_rd}, 11);
    set_issue(1, 4, 11, 32'h11, 32'h12); set_cdb(14, 32'h77); tick();
    chk("t3_notfull", {31'b0, full}, 0);
    chk("t3_selC", {27'b0, iss_rd}, 12);
    set_issue(1, 5, 12, 32'h21, 32'h22); tick();
    chk("t3_selE", {27'b0, iss_rd}, 14);
    disp_rdy(6, 13, 32'h31, 32'h32); set_cdb(9, 32'h99); tick();
    set_issue(1, 3, 10, 32'h99, 2); tick();
    set_issue(1, 7, 14, 32'h41, 32'h77); tick();
    set_issue(1, 6, 13, 32'h31, 32'h32); tick();
    chk("t3_empty", {31'b0, ready}, 0);

    // Grant with nothing ready is ignored
    set_issue(0, 0, 0, 0, 0); tick();
    chk("t3_idle_full", {31'b0, full}, 0);

    // Full with simultaneous dispatch and issue
    for (int i = 0; i < 4; i++) begin
      disp_rdy(3'(i), 5'(16 + i), 32'h100 + i, 32'h200 + i); tick();
    end
    chk("t4_full", {31'b0, full}, 1);
    disp_rdy(7, 20, 32'hEE, 32'hEF); set_issue(1, 0, 16, 32'h100, 32'h200); tick();
    chk("t4_dropped", {31'b0, full}, 0);
    disp_rdy(5, 21, 32'h300, 32'h301); tick();
    chk("t4_refull", {31'b0, full}, 1);
    set_issue(1, 1, 17, 32'h101, 32'h201); tick();
    set_issue(1, 2, 18, 32'h102, 32'h202); tick();
    set_issue(1, 3, 19, 32'h103, 32'h203); tick();
    set_issue(1, 5, 21, 32'h300, 32'h301); tick();
    chk("t4_empty", {31'b0, ready}, 0);

    // Same-cycle bypass
    set_disp(1, 22, 1, 0, 5, 0, 12, 32'hDEAD); set_cdb(12, 32'h1234); tick();
    chk("t5_ready", {31'b0, ready}, 1);
    chk("t5_rtdata", iss_rt, 32'h1234);
    set_issue(1, 1, 22, 5, 32'h1234); tick();

    // Flush beats dispatch; then count must restart from zero
    for (int i = 0; i < 3; i++) begin
      disp_rdy(2, 5'(24 + i), i, i); tick();
    end
    chk("t6_prefl", {31'b0, ready}, 1);
    flush = 1; disp_rdy(4, 30, 1, 1); tick();
    chk("t6_fl_ready", {31'b0, ready}, 0);
    chk("t6_fl_full",  {31'b0, full}, 0);
    for (int i = 0; i < 3; i++) begin
      disp_rdy(6, 5'(i), 32'h40 + i, 32'h50 + i); tick();
    end
    chk("t6_three", {31'b0, full}, 0);
    chk("t6_head", {27'b0, iss_rd}, 0);
    disp_rdy(6, 3, 32'h43, 32'h53); tick();
    chk("t6_four", {31'b0, full}, 1);

    // Asynchronous reset between edges
    #2 rst = 1;
    #1;
    chk("t6_async_ready", {31'b0, ready}, 0);
    chk("t6_async_full",  {31'b0, full}, 0);
    chk("t6_async_rdtag", {27'b0, iss_rd}, 0);
    @(posedge clk);
    #1 rst = 0;
    tick();
    chk("t6_post_ready", {31'b0, ready}, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_issue_queue.md
# int_issue_queue

Age-ordered, 4-entry integer issue queue that sits directly upstream of the issue/CDB arbiter. It accepts dispatched integer instructions, holds them until both source operands are available, and snoops the CDB to capture missing operands. It presents the oldest ready entry to the arbiter as Ready_Int. It removes that entry when the arbiter answers with Issue_Int, and in the same cycle drives the operands to the integer ALU, whose result the arbiter captures onto the CDB.

## Interface
- DEPTH, 4, number of entries (≥2)
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Flush  in  1  synchronous clear of all entries (branch mispredict)
- Dispatch_En  in  1  write a new entry this cycle
- Dispatch_Opcode  in  3  ALU operation code
- Dispatch_RdTag  in  5  destination ROB tag
- Dispatch_RsValid / Dispatch_RtValid  in  1 each  operand already available
- Dispatch_RsTag / Dispatch_RtTag  in  5 each  producer tag when operand not valid
- Dispatch_RsData / Dispatch_RtData  in  32 each  operand value when valid
- Queue_Full  out  1  no free entry; dispatch is dropped
- CDB_Valid  in  1  CDB broadcast valid
- CDB_Tag  in  5  broadcast tag
- CDB_Data  in  32  broadcast value
- Ready_Int  out  1  at least one entry has both operands valid
- Issue_Int  in  1  arbiter grant; removes the selected entry this cycle
- Issue_Opcode  out  3  opcode of selected entry
- Issue_RdTag  out  5  destination tag of selected entry
- Issue_RsData / Issue_RtData  out  32 each  operand values of selected entry

## Operation
- Entry fields: Valid, Opcode, RdTag, RsValid, RsTag, RsData, RtValid, RtTag, RtData.
- Storage is a compacting queue. Entry 0 is the oldest and valid entries are always contiguous from 0. Count is 0..DEPTH.
- Ready per entry = Valid & RsValid & RtValid. Selected entry = the lowest-index ready entry.
- Ready_Int and Issue_* are combinational from registered state only, with no path from Issue_Int or CDB_*. Issue_* is all-zero when Ready_Int=0.
- Issue: when Issue_Int=1 and Ready_Int=1, the selected entry is removed at the clock edge. Every valid entry above it shifts down one and count decrements. Issue_Int=1 with Ready_Int=0 is ignored.
- Dispatch: accepted when Dispatch_En=1 and Queue_Full=0. The new entry is written at index count, or count-1 when an issue also occurs in the same cycle. Dispatch_En while full is dropped with no state change.
- Queue_Full = (count==DEPTH), based on registered count. A same-cycle issue does not free a slot for a dispatch that arrives while full.
- CDB snoop: when CDB_Valid=1, every valid entry whose operand is not yet valid and whose tag equals CDB_Tag captures CDB_Data and sets that valid bit. This applies to Rs and Rt independently and is applied together with the shift, so data lands in the entry's post-shift slot.
- Dispatch bypass: if a dispatched operand is not valid and its tag equals CDB_Tag while CDB_Valid=1 in the same cycle, the operand is written already valid with CDB_Data.
- The snoop does not update the entry being issued in the same cycle, since its operands are already valid.
- Flush=1: all entries are invalidated at the edge and count goes to 0. Flush has priority over dispatch, issue and snoop.
- Reset: all entries are invalid and count=0. Queue_Full=0, Ready_Int=0, all Issue_* outputs=0.

## Timing
- Dispatch → earliest Ready_Int: 1 cycle, when both operands are valid at dispatch or bypassed.
- CDB broadcast of a missing tag → Ready_Int for that entry on the next cycle.
- Issue_Int is sampled on the same cycle that Issue_* is presented. The arbiter registers the ALU result at that edge.
- Back-to-back issue is possible every cycle while ready entries exist.
- Rst asserted mid-operation clears state immediately, without waiting for a clock edge. Outputs take their reset values while Rst=1.

## Test plan
- **Reset and basic issue:** after reset, check Ready_Int=0 and Queue_Full=0. Dispatch Opcode=2, RdTag=5, Rs=10 valid, Rt=20 valid. Next cycle: Ready_Int=1, Issue_RdTag=5, RsData=10, RtData=20. Assert Issue_Int; next cycle Ready_Int=0.
- **Wakeup:** dispatch RdTag=3 with Rs waiting on tag 7 and Rt=1 valid. Ready_Int stays 0. Broadcast CDB tag 7, data 0xAA. Next cycle: Ready_Int=1 and Issue_RsData=0xAA. A broadcast of tag 8 causes no change.
- **Age order with a hole:** dispatch A (waiting on tag 9), then B and C (both ready). Ready selects B. Issue B; C shifts into slot 1 and is selected next. Broadcast tag 9; A (slot 0) is selected before any later entry.
- **Full and simultaneous events:** fill with 4 entries and check Queue_Full=1. Dispatch with Issue_Int=1 in the same cycle: the dispatch is dropped and count becomes 3. Next dispatch is accepted at slot 3.
- **Same-cycle bypass:** dispatch with Rt waiting on tag 12 while the CDB broadcasts tag 12, data 0x1234. Next cycle: Ready_Int=1 and Issue_RtData=0x1234.
- **Flush and asynchronous reset:** with 3 entries, assert Flush together with Dispatch_En. Next cycle: count=0 and Ready_Int=0. Refill, then pulse Rst between clock edges: Ready_Int falls immediately.
